// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared segment patterns and digit count for the scanned display
package clock_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam seg_t SEG_0    = 7'h40;
  localparam seg_t SEG_1    = 7'h79;
  localparam seg_t SEG_2    = 7'h24;
  localparam seg_t SEG_3    = 7'h30;
  localparam seg_t SEG_4    = 7'h19;
  localparam seg_t SEG_5    = 7'h12;
  localparam seg_t SEG_6    = 7'h02;
  localparam seg_t SEG_7    = 7'h78;
  localparam seg_t SEG_8    = 7'h00;
  localparam seg_t SEG_9    = 7'h10;
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD nibble to active-low segment pattern
module bcd_to_seg7
  import clock_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed 7-segment scan driver with frame snapshot
// Optional LEADING_ZERO_BLANK_EN: blank digit 3 when its snapshot value is zero.
module seg7_scan_driver
  import clock_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 16
)
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [15:0]           i_bcd,
  input  logic [NUM_DIGITS-1:0] i_dp,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [NUM_DIGITS-1:0] o_an,
  output logic                  o_frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0]           cnt;
  logic [1:0]              idx;
  logic [15:0]             snap_bcd;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    last;
  logic                    capture;
  logic                    lead_blank;
  logic                    lit;
  logic [3:0]              nibble;
  seg_t                    dec_seg;

  assign last    = (cnt == CW'(DIV - 1));
  assign capture = last && (idx == 2'd3);
  assign nibble  = snap_bcd[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  assign lead_blank = (idx == 2'd3) && (snap_bcd[15:12] == 4'd0);
`else
  assign lead_blank = 1'b0;
`endif

  // Digit is driven only after the anti-ghost gap at the start of its slot
  assign lit = (cnt >= CW'(BLANK)) && !lead_blank;

  bcd_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt      <= '0;
      idx      <= 2'd0;
      snap_bcd <= '0;
      snap_dp  <= '0;
      o_an     <= '1;
      o_seg    <= SEG_OFF;
      o_dp     <= 1'b1;
      o_frame  <= 1'b0;
    end else begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (last)
        idx <= idx + 2'd1;
      // Snapshot on the final clock of digit 3 so a frame never mixes old and new data
      if (capture) begin
        snap_bcd <= i_bcd;
        snap_dp  <= i_dp;
      end
      o_frame <= capture;
      if (lit) begin
        o_an  <= ~(NUM_DIGITS'(1) << idx);
        o_seg <= dec_seg;
        o_dp  <= ~snap_dp[idx];
      end else begin
        o_an  <= '1;
        o_seg <= SEG_OFF;
        o_dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver (DIV=8, BLANK=2)
module tb_seg7_scan_driver;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bcd = 16'h0000;
  logic [3:0]  dp  = 4'h0;
  logic [6:0]  seg;
  logic        dpo;
  logic [3:0]  an;
  logic        frame;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_bcd   (bcd),
    .i_dp    (dp),
    .o_seg   (seg),
    .o_dp    (dpo),
    .o_an    (an),
    .o_frame (frame)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  typedef struct {
    string            name;
    logic [15:0]      bcd;
    logic [3:0]       dp;
    logic [3:0][6:0]  segs;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic push_frame(input logic [3:0][6:0] s, input logic [3:0] d, input logic d3zero);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < DIV; c++) begin
        exp_t e;
        logic blank;
        blank   = (c < BLANK) || (LZB && (k == 3) && d3zero);
        e.an    = blank ? 4'hF : ~(4'(1) << k);
        e.seg   = blank ? 7'h7F : s[k];
        e.dp    = blank ? 1'b1 : ~d[k];
        e.frame = (k == 3) && (c == DIV - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s sample %0d: scoreboard empty", tag, i);
      end else begin
        e = sb.pop_front();
        if ({an, seg, dpo, frame} !== e) begin
          errors++;
          $display("FAIL %s sample %0d: got an=%h seg=%h dp=%b frame=%b, want an=%h seg=%h dp=%b frame=%b",
                   tag, i, an, seg, dpo, frame, e.an, e.seg, e.dp, e.frame);
        end
      end
    end
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame !== 1'b1 && n < 200);
    checks++;
    if (frame !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_timeout: frame=%b after %0d clocks, want 1", tag, frame, n);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    checks++;
    if ({an, seg, dpo, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s: got an=%h seg=%h dp=%b frame=%b, want an=f seg=7f dp=1 frame=0",
               tag, an, seg, dpo, frame);
    end
  endtask

  initial begin
    vecs[0] = '{"scan_1259",  16'h1259, 4'b0000, {7'h79, 7'h24, 7'h12, 7'h10}};
    vecs[1] = '{"dash_12A9",  16'h12A9, 4'b0000, {7'h79, 7'h24, 7'h3F, 7'h10}};
    vecs[2] = '{"dp_digit2",  16'h1259, 4'b0100, {7'h79, 7'h24, 7'h12, 7'h10}};
    vecs[3] = '{"lead_0930",  16'h0930, 4'b0000, {7'h40, 7'h10, 7'h30, 7'h40}};
    vecs[4] = '{"all_8647",   16'h8647, 4'b1111, {7'h00, 7'h02, 7'h19, 7'h78}};
    vecs[5] = '{"dash_FEDC",  16'hFEDC, 4'b0001, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};

    #1 rst = 1'b1;
    #2 check_reset_pins("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_frame({4{7'h40}}, 4'h0, 1'b1);
    drain(32, "post_reset_0000");

    foreach (vecs[i]) begin
      bcd = vecs[i].bcd;
      dp  = vecs[i].dp;
      wait_frame(vecs[i].name);
      push_frame(vecs[i].segs, vecs[i].dp, vecs[i].bcd[15:12] == 4'd0);
      drain(32, vecs[i].name);
    end

    // Input changes mid-frame must not tear the displayed frame
    bcd = 16'h1259;
    dp  = 4'h0;
    wait_frame("tear_setup");
    push_frame({7'h79, 7'h24, 7'h12, 7'h10}, 4'h0, 1'b0);
    push_frame({7'h40, 7'h79, 7'h40, 7'h40}, 4'h0, 1'b1);
    drain(10, "tear_old");
    bcd = 16'h0100;
    drain(54, "tear_new");

    // Asynchronous reset in the lit part of a slot
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (an === 4'hF && n < 50);
      checks++;
      if (an === 4'hF) begin
        errors++;
        $display("FAIL reset_mid_slot_setup: an=%h, want a lit digit", an);
      end
    end
    #2 rst = 1'b1;
    #1 check_reset_pins("async_reset_mid_slot");
    @(negedge clk);
    check_reset_pins("reset_held");
    rst = 1'b0;
    push_frame({4{7'h40}}, 4'h0, 1'b1);
    drain(32, "after_mid_reset");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
